// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC_SPM control unit: controller states,
// instruction opcodes and the bus source select encodings.
package risc_spm_pkg;

    // Controller states; IDLE is the reset state.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    // Instruction opcodes carried in instr[7:4]; 9..15 are illegal.
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_NOT = 4'd4,
        OP_RD  = 4'd5,
        OP_WR  = 4'd6,
        OP_BR  = 4'd7,
        OP_BRZ = 4'd8
    } opcode_t;

    // Bus_1 source selects.
    localparam logic [2:0] SEL1_R0 = 3'd0;
    localparam logic [2:0] SEL1_R1 = 3'd1;
    localparam logic [2:0] SEL1_R2 = 3'd2;
    localparam logic [2:0] SEL1_R3 = 3'd3;
    localparam logic [2:0] SEL1_PC = 3'd4;

    // Bus_2 source selects.
    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    // Bus_1 select for a register field of the instruction.
    function automatic logic [2:0] reg_sel(input logic [1:0] r);
        return {1'b0, r};
    endfunction

    // One-hot register load enable for a register field.
    function automatic logic [3:0] reg_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/risc_spm_ctrl.sv
// RISC_SPM control unit: a state register plus a combinational decode that
// produces the datapath strobes from the current state, instruction and zero flag.
module risc_spm_ctrl
    import risc_spm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic       zflag,
    output logic [3:0] load_r,
    output logic       load_pc,
    output logic       inc_pc,
    output logic [2:0] sel_bus1,
    output logic [1:0] sel_bus2,
    output logic       load_ir,
    output logic       load_add_r,
    output logic       load_reg_y,
    output logic       load_reg_z,
    output logic       mem_write,
    output logic       halted
);

    state_t     state;
    state_t     next_state;
    logic [3:0] opcode;
    logic [1:0] src;
    logic [1:0] dest;

    assign opcode = instr[7:4];
    assign src    = instr[3:2];
    assign dest   = instr[1:0];

    // State register; reset drops straight to IDLE so every strobe clears at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; everything idles at 0 unless the state drives it.
    always_comb begin
        next_state = state;
        load_r     = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        sel_bus1   = SEL1_R0;
        sel_bus2   = SEL2_ALU;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        mem_write  = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = S_FET1;
            end

            S_FET1: begin
                sel_bus1   = SEL1_PC;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_FET2;
            end

            S_FET2: begin
                sel_bus2   = SEL2_MEM;
                load_ir    = 1'b1;
                next_state = S_DEC;
            end

            S_DEC: begin
                case (opcode)
                    OP_NOP: begin
                        next_state = S_FET1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus1   = reg_sel(src);
                        load_reg_y = 1'b1;
                        next_state = S_EX1;
                    end
                    OP_NOT: begin
                        sel_bus1   = reg_sel(src);
                        sel_bus2   = SEL2_ALU;
                        load_reg_z = 1'b1;
                        load_r     = reg_onehot(dest);
                        next_state = S_FET1;
                    end
                    OP_RD: begin
                        sel_bus1   = SEL1_PC;
                        load_add_r = 1'b1;
                        inc_pc     = 1'b1;
                        next_state = S_RD1;
                    end
                    OP_WR: begin
                        sel_bus1   = SEL1_PC;
                        load_add_r = 1'b1;
                        inc_pc     = 1'b1;
                        next_state = S_WR1;
                    end
                    OP_BR: begin
                        sel_bus1   = SEL1_PC;
                        load_add_r = 1'b1;
                        next_state = S_BR1;
                    end
                    OP_BRZ: begin
                        if (zflag) begin
                            sel_bus1   = SEL1_PC;
                            load_add_r = 1'b1;
                            next_state = S_BR1;
                        end else begin
                            inc_pc     = 1'b1;
                            next_state = S_FET1;
                        end
                    end
                    default: begin
                        next_state = S_HALT;
                    end
                endcase
            end

            S_EX1: begin
                sel_bus1   = reg_sel(dest);
                sel_bus2   = SEL2_ALU;
                load_reg_z = 1'b1;
                load_r     = reg_onehot(dest);
                next_state = S_FET1;
            end

            S_RD1: begin
                sel_bus2   = SEL2_MEM;
                load_add_r = 1'b1;
                next_state = S_RD2;
            end

            S_RD2: begin
                sel_bus2   = SEL2_MEM;
                load_r     = reg_onehot(dest);
                next_state = S_FET1;
            end

            S_WR1: begin
                sel_bus2   = SEL2_MEM;
                load_add_r = 1'b1;
                next_state = S_WR2;
            end

            S_WR2: begin
                sel_bus1   = reg_sel(src);
                mem_write  = 1'b1;
                next_state = S_FET1;
            end

            S_BR1: begin
                sel_bus2   = SEL2_MEM;
                load_add_r = 1'b1;
                next_state = S_BR2;
            end

            S_BR2: begin
                sel_bus2   = SEL2_MEM;
                load_pc    = 1'b1;
                next_state = S_FET1;
            end

            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_risc_spm_ctrl.sv
// Self-checking bench for risc_spm_ctrl: per-instruction cycle tables plus
// hand-written HALT and mid-instruction reset sequences, checked via a scoreboard.
module tb_risc_spm_ctrl;
    import risc_spm_pkg::*;

    typedef struct packed {
        logic       halted;
        logic       mem_write;
        logic       load_reg_z;
        logic       load_reg_y;
        logic       load_add_r;
        logic       load_ir;
        logic [1:0] sel_bus2;
        logic [2:0] sel_bus1;
        logic       inc_pc;
        logic       load_pc;
        logic [3:0] load_r;
    } out_t;

    typedef struct packed {
        logic [7:0]     instr;
        logic           zflag;
        logic [2:0]     n;
        out_t [4:0]     exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       zflag;
    logic [3:0] load_r;
    logic       load_pc;
    logic       inc_pc;
    logic [2:0] sel_bus1;
    logic [1:0] sel_bus2;
    logic       load_ir;
    logic       load_add_r;
    logic       load_reg_y;
    logic       load_reg_z;
    logic       mem_write;
    logic       halted;

    out_t act;
    out_t sb_q[$];
    vec_t vecs[12];
    int   total;
    int   bad;

    risc_spm_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zflag      (zflag),
        .load_r     (load_r),
        .load_pc    (load_pc),
        .inc_pc     (inc_pc),
        .sel_bus1   (sel_bus1),
        .sel_bus2   (sel_bus2),
        .load_ir    (load_ir),
        .load_add_r (load_add_r),
        .load_reg_y (load_reg_y),
        .load_reg_z (load_reg_z),
        .mem_write  (mem_write),
        .halted     (halted)
    );

    assign act = '{halted: halted, mem_write: mem_write, load_reg_z: load_reg_z,
                   load_reg_y: load_reg_y, load_add_r: load_add_r, load_ir: load_ir,
                   sel_bus2: sel_bus2, sel_bus1: sel_bus1, inc_pc: inc_pc,
                   load_pc: load_pc, load_r: load_r};

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t mk(input logic [2:0] s1, input logic [1:0] s2,
                                input logic [3:0] lr, input logic la, input logic ipc,
                                input logic lpc, input logic lir, input logic ly,
                                input logic lz, input logic mw, input logic h);
        out_t o;
        o.sel_bus1   = s1;
        o.sel_bus2   = s2;
        o.load_r     = lr;
        o.load_add_r = la;
        o.inc_pc     = ipc;
        o.load_pc    = lpc;
        o.load_ir    = lir;
        o.load_reg_y = ly;
        o.load_reg_z = lz;
        o.mem_write  = mw;
        o.halted     = h;
        return o;
    endfunction

    task automatic push_exp(input out_t e);
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(input vec_t v);
        instr = v.instr;
        zflag = v.zflag;
        for (int i = 0; i < int'(v.n); i++) push_exp(v.exp[i]);
    endtask

    task automatic check_output(input string name);
        out_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: got %h want <scoreboard empty>", name, act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL %s: got %h want %h", name, act, e);
            end
        end
        total++;
        if (!$onehot0(act.load_r) || (act.mem_write && (act.load_r != 4'b0000))) begin
            bad++;
            $display("[TB] FAIL %s_excl: got load_r=%b mem_write=%b want onehot0 and exclusive",
                     name, act.load_r, act.mem_write);
        end
    endtask

    task automatic run_vec(input int idx);
        @(negedge clk);
        apply_stimulus(vecs[idx]);
        #1;
        for (int i = 0; i < int'(vecs[idx].n); i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check_output($sformatf("vec%0d_i%02h_cyc%0d", idx, vecs[idx].instr, i));
        end
    endtask

    initial begin
        out_t fet1, fet2, zero, hlt, br1, fetch_pc, rdwr1;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        instr = 8'h00;
        zflag = 1'b0;

        fet1     = mk(SEL1_PC, SEL2_ALU, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 0);
        fet2     = mk(SEL1_R0, SEL2_MEM, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0);
        zero     = mk(SEL1_R0, SEL2_ALU, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        hlt      = mk(SEL1_R0, SEL2_ALU, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
        fetch_pc = mk(SEL1_PC, SEL2_ALU, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 0);
        rdwr1    = mk(SEL1_R0, SEL2_MEM, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
        br1      = mk(SEL1_PC, SEL2_ALU, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = '{instr: 8'h00, zflag: 1'b0, n: 3'd3, exp: '{zero, zero, zero, fet2, fet1}};
        vecs[1]  = '{instr: 8'h00, zflag: 1'b1, n: 3'd3, exp: '{zero, zero, zero, fet2, fet1}};
        vecs[2]  = '{instr: 8'h16, zflag: 1'b0, n: 3'd4, exp: '{zero,
                     mk(SEL1_R2, SEL2_ALU, 4'b0100, 0, 0, 0, 0, 0, 1, 0, 0),
                     mk(SEL1_R1, SEL2_ALU, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0), fet2, fet1}};
        vecs[3]  = '{instr: 8'h2B, zflag: 1'b0, n: 3'd4, exp: '{zero,
                     mk(SEL1_R3, SEL2_ALU, 4'b1000, 0, 0, 0, 0, 0, 1, 0, 0),
                     mk(SEL1_R2, SEL2_ALU, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0), fet2, fet1}};
        vecs[4]  = '{instr: 8'h3C, zflag: 1'b1, n: 3'd4, exp: '{zero,
                     mk(SEL1_R0, SEL2_ALU, 4'b0001, 0, 0, 0, 0, 0, 1, 0, 0),
                     mk(SEL1_R3, SEL2_ALU, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0), fet2, fet1}};
        vecs[5]  = '{instr: 8'h4D, zflag: 1'b0, n: 3'd3, exp: '{zero, zero,
                     mk(SEL1_R3, SEL2_ALU, 4'b0010, 0, 0, 0, 0, 0, 1, 0, 0), fet2, fet1}};
        vecs[6]  = '{instr: 8'h5B, zflag: 1'b0, n: 3'd5, exp: '{
                     mk(SEL1_R0, SEL2_MEM, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0),
                     rdwr1, fetch_pc, fet2, fet1}};
        vecs[7]  = '{instr: 8'h64, zflag: 1'b0, n: 3'd5, exp: '{
                     mk(SEL1_R1, SEL2_ALU, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0),
                     rdwr1, fetch_pc, fet2, fet1}};
        vecs[8]  = '{instr: 8'h70, zflag: 1'b0, n: 3'd5, exp: '{
                     mk(SEL1_R0, SEL2_MEM, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0),
                     rdwr1, br1, fet2, fet1}};
        vecs[9]  = '{instr: 8'h80, zflag: 1'b0, n: 3'd3, exp: '{zero, zero,
                     mk(SEL1_R0, SEL2_ALU, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0), fet2, fet1}};
        vecs[10] = '{instr: 8'h80, zflag: 1'b1, n: 3'd5, exp: '{
                     mk(SEL1_R0, SEL2_MEM, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0),
                     rdwr1, br1, fet2, fet1}};
        vecs[11] = '{instr: 8'h00, zflag: 1'b0, n: 3'd3, exp: '{zero, zero, zero, fet2, fet1}};

        // Reset asserted from time 0: outputs must be idle before any clock edge
        #3;
        push_exp(zero);
        check_output("reset_async");

        // Still IDLE once reset lifts, until the first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_exp(zero);
        check_output("idle_after_release");

        for (int k = 0; k < 12; k++) run_vec(k);

        // Illegal opcode halts; HALT holds with only halted set
        @(negedge clk);
        instr = 8'hF0;
        zflag = 1'b0;
        push_exp(fet1);
        push_exp(fet2);
        push_exp(zero);
        for (int i = 0; i < 22; i++) push_exp(hlt);
        #1;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check_output($sformatf("halt_cyc%0d", i));
        end

        // Reset pulse inside a cycle clears HALT without waiting for an edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(zero);
        check_output("halt_reset_async");
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch restarts, RD runs into RD1, then reset abandons it
        @(negedge clk);
        instr = 8'h5B;
        push_exp(fet1);
        push_exp(fet2);
        push_exp(fetch_pc);
        push_exp(rdwr1);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check_output($sformatf("rd_abort_cyc%0d", i));
        end
        rst_n = 1'b0;
        #1;
        push_exp(zero);
        check_output("rd1_reset_async");
        @(negedge clk);
        push_exp(zero);
        #1;
        check_output("rd1_reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        instr = 8'h00;
        push_exp(fet1);
        #1;
        check_output("restart_fet1");
        @(negedge clk);
        push_exp(fet2);
        #1;
        check_output("restart_fet2");

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
